// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - mode encodings, coefficient/offset tables and latency for ycbcr_csc
package csc_pkg;

  typedef enum logic [1:0] {
    MODE_601_FULL = 2'd0,
    MODE_709_FULL = 2'd1,
    MODE_601_LIM  = 2'd2,
    MODE_BYPASS   = 2'd3
  } mode_e;

  localparam int CSC_LAT = 4;

  // [mode][Y,Cb,Cr][R,G,B] at 8 fractional bits; bypass is an exact unity routing matrix
  localparam int COEF_TBL [4][3][3] = '{
    '{'{ 77, 150,  29}, '{-43,  -85, 128}, '{128, -107, -21}},
    '{'{ 54, 183,  19}, '{-29,  -99, 128}, '{128, -116, -12}},
    '{'{ 66, 129,  25}, '{-38,  -74, 112}, '{112,  -94, -18}},
    '{'{  0, 256,   0}, '{  0,    0, 256}, '{256,    0,   0}}
  };

  localparam logic [7:0] OFF_TBL [4][3] = '{
    '{8'd0,  8'd128, 8'd128},
    '{8'd0,  8'd128, 8'd128},
    '{8'd16, 8'd128, 8'd128},
    '{8'd0,  8'd0,   8'd0}
  };

endpackage

// File: rtl/csc_dot3.sv
// rtl/csc_dot3.sv - one output component: products, offset sum, round/shift/clamp (3 stages)
module csc_dot3
  import csc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          x0_i,
  input  logic [DW-1:0]          x1_i,
  input  logic [DW-1:0]          x2_i,
  input  logic signed [FRAC+2:0] c0_i,
  input  logic signed [FRAC+2:0] c1_i,
  input  logic signed [FRAC+2:0] c2_i,
  input  logic [7:0]             off_i,
  output logic [DW-1:0]          res_o
);

  localparam int PW  = DW + FRAC + 4;
  localparam int SW  = DW + FRAC + 5;
  localparam int OSH = DW - 8 + FRAC;
  localparam logic signed [SW-1:0] RND  = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** DW) - 1);

  logic signed [PW-1:0] p0_d, p1_d, p2_d, p0_q, p1_q, p2_q;
  logic [7:0]           off_d, off_q;
  logic signed [SW-1:0] sum_d, sum_q, shf;
  logic [DW-1:0]        res_d, res_q;

  always_comb begin
    p0_d  = PW'(c0_i) * PW'($signed({1'b0, x0_i}));
    p1_d  = PW'(c1_i) * PW'($signed({1'b0, x1_i}));
    p2_d  = PW'(c2_i) * PW'($signed({1'b0, x2_i}));
    off_d = off_i;
    sum_d = SW'(p0_q) + SW'(p1_q) + SW'(p2_q)
          + (SW'($signed({1'b0, off_q})) <<< OSH) + RND;
    shf   = sum_q >>> FRAC;
    if (shf[SW-1]) begin
      res_d = '0;
    end else if (shf > MAXV) begin
      res_d = '1;
    end else begin
      res_d = shf[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      off_q <= '0;
      sum_q <= '0;
      res_q <= '0;
    end else begin
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      off_q <= off_d;
      sum_q <= sum_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/ycbcr_csc.sv
// rtl/ycbcr_csc.sv - RGB to YCbCr converter with frame-latched mode and optional 4:2:2 output
module ycbcr_csc
  import csc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsync_i,
  input  logic            vsync_i,
  input  logic            de_i,
  input  logic [3*DW-1:0] data_i,
  input  logic [1:0]      mode_i,
  input  logic            out422_i,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            de_o,
  output logic [DW-1:0]   data_y,
  output logic [DW-1:0]   data_cb,
  output logic [DW-1:0]   data_cr
);

  localparam int CW = FRAC + 3;

  mode_e                mode_d, mode_q;
  logic                 o422_d, o422_q, vs_prev_d, vs_prev_q;
  logic [CSC_LAT-1:0]   hs_sr_d, hs_sr_q, vs_sr_d, vs_sr_q, de_sr_d, de_sr_q;
  logic [CSC_LAT-2:0]   fmt_sr_d, fmt_sr_q;
  logic signed [CW-1:0] coef [3][3];
  logic [7:0]           off [3];
  logic [DW-1:0]        comp [3];
  logic [DW-1:0]        y_d, y_q, cb_d, cb_q, cr_d, cr_q, hold_d, hold_q;
  logic                 phase_d, phase_q, ph;

  always_comb begin
    mode_d    = mode_q;
    o422_d    = o422_q;
    vs_prev_d = vsync_i;
    if (vsync_i && !vs_prev_q) begin
      mode_d = mode_e'(mode_i);
      o422_d = out422_i;
    end
    hs_sr_d  = {hs_sr_q[CSC_LAT-2:0], hsync_i};
    vs_sr_d  = {vs_sr_q[CSC_LAT-2:0], vsync_i};
    de_sr_d  = {de_sr_q[CSC_LAT-2:0], de_i};
    // format bit travels with its pixel so stage 4 sees the setting the pixel entered with
    fmt_sr_d = {fmt_sr_q[CSC_LAT-3:0], o422_q};
    for (int k = 0; k < 3; k++) begin
      off[k] = OFF_TBL[mode_q][k];
      for (int i = 0; i < 3; i++) begin
        coef[k][i] = CW'(COEF_TBL[mode_q][k][i] <<< (FRAC - 8));
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_comp
    csc_dot3 #(.DW(DW), .FRAC(FRAC)) u_dot3 (
      .clk   (clk),
      .rst   (rst),
      .x0_i  (data_i[3*DW-1 -: DW]),
      .x1_i  (data_i[2*DW-1 -: DW]),
      .x2_i  (data_i[DW-1:0]),
      .c0_i  (coef[k][0]),
      .c1_i  (coef[k][1]),
      .c2_i  (coef[k][2]),
      .off_i (off[k]),
      .res_o (comp[k])
    );
  end

  // stage 4: phase restarts whenever the previous output cycle was blanking
  always_comb begin
    y_d     = '0;
    cb_d    = '0;
    cr_d    = '0;
    hold_d  = '0;
    phase_d = 1'b0;
    ph      = de_sr_q[CSC_LAT-1] ? phase_q : 1'b0;
    if (de_sr_q[CSC_LAT-2]) begin
      y_d     = comp[0];
      phase_d = ~ph;
      if (fmt_sr_q[CSC_LAT-2]) begin
        cb_d   = ph ? hold_q : comp[1];
        hold_d = ph ? hold_q : comp[2];
      end else begin
        cb_d = comp[1];
        cr_d = comp[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_601_FULL;
      o422_q    <= 1'b0;
      // a vsync already high across reset release is not a fresh frame start
      vs_prev_q <= vsync_i;
      hs_sr_q   <= '0;
      vs_sr_q   <= '0;
      de_sr_q   <= '0;
      fmt_sr_q  <= '0;
      y_q       <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
      hold_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      o422_q    <= o422_d;
      vs_prev_q <= vs_prev_d;
      hs_sr_q   <= hs_sr_d;
      vs_sr_q   <= vs_sr_d;
      de_sr_q   <= de_sr_d;
      fmt_sr_q  <= fmt_sr_d;
      y_q       <= y_d;
      cb_q      <= cb_d;
      cr_q      <= cr_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
    end
  end

  assign hsync_o = hs_sr_q[CSC_LAT-1];
  assign vsync_o = vs_sr_q[CSC_LAT-1];
  assign de_o    = de_sr_q[CSC_LAT-1];
  assign data_y  = y_q;
  assign data_cb = cb_q;
  assign data_cr = cr_q;

endmodule
